cache_miss_sequencer: RTL and testbench
=======================================

Name: cache_miss_sequencer

Overview:
Sequences one cache-line miss around the way-replacement block and the tag/data arrays.
- Accepts a miss request and captures the victim way chosen by the replacement logic.
- Writes the victim back over the bus if it is dirty, then fills the line.
- Commits valid/dirty/LRU updates and signals completion to the LSU/IFU stall logic.
- One instance per cache, between the cache arrays and the bus interface.

Parameters:
NUMWAYS, 4, associativity (power of 2, 2..128)
SETLEN, 7, set-index width
BEATSPERLINE, 4, bus beats per line (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
FlushStage  in  1  pipeline flush; may cancel a not-yet-started miss
MissReq  in  1  miss request valid
MissSet  in  SETLEN  set index of the miss
MissReady  out  1  sequencer can accept a request
VictimWay  in  NUMWAYS  one-hot victim from replacement logic; valid the cycle after acceptance
DirtyWay  in  NUMWAYS  per-way dirty bits of the addressed set; valid the cycle after acceptance
VictimWayQ  out  NUMWAYS  latched one-hot victim, drives array way-selects
SetQ  out  SETLEN  latched set index
BusReq  out  1  bus transaction active
BusWrite  out  1  1 = writeback, 0 = fill
BusAck  in  1  one beat transferred this cycle
BeatCount  out  log2(BEATSPERLINE)  current beat index
ClearValid  out  1  invalidate the victim line (1-cycle pulse)
SetValid  out  1  mark the filled line valid (1-cycle pulse)
ClearDirty  out  1  mark the filled line clean (1-cycle pulse)
LRUWriteEn  out  1  update replacement state (1-cycle pulse)
MissDone  out  1  miss complete (1-cycle pulse)

Behaviour:
- States: IDLE, CAPTURE, EVICT, FILL, COMMIT.
- Reset (reset=0, async): state IDLE; BeatCount 0; VictimWayQ 0; SetQ 0; all pulse outputs 0; BusReq/BusWrite 0. MissReady=1 once reset deasserts.
- IDLE: MissReady=1.
  - MissReq=1 and FlushStage=0 → latch MissSet into SetQ, go to CAPTURE.
  - MissReq=1 and FlushStage=1 → request ignored, stay IDLE.
- CAPTURE (arrays read for one cycle):
  - Latch VictimWay into VictimWayQ.
  - FlushStage=1 → IDLE; no bus activity, no array pulses.
  - Otherwise → EVICT if |(VictimWay & DirtyWay), else FILL.
- EVICT:
  - BusReq=1, BusWrite=1.
  - Each BusAck increments BeatCount.
  - Ack on beat BEATSPERLINE-1 → BeatCount wraps to 0, go to FILL.
- FILL:
  - BusReq=1, BusWrite=0.
  - ClearValid pulses on the first FILL cycle only.
  - Beat counting as in EVICT; last ack → COMMIT.
- COMMIT (exactly 1 cycle):
  - SetValid=ClearDirty=LRUWriteEn=MissDone=1.
  - BusReq=0.
  - Next state IDLE.
- No BusAck → hold state and BeatCount indefinitely; no timeout.
- FlushStage in EVICT, FILL or COMMIT is ignored; the sequence runs to completion.
- MissReady=0 outside IDLE; MissReq there is ignored. A new request is accepted in the cycle after COMMIT at the earliest.
- BusAck while BusReq=0 is ignored.
- Latency with BusAck held high (accept cycle = 0):
  - Clean miss: MissDone at cycle 2+BEATSPERLINE.
  - Dirty miss: MissDone at cycle 2+2·BEATSPERLINE.
- Reset asserted mid-burst → immediate IDLE; no pulse outputs during or after.
- VictimWayQ and SetQ hold their values from CAPTURE until the next accepted request.

Decomposition:
- Package cache_seq_pkg: enum typedef seqstate_t {IDLE, CAPTURE, EVICT, FILL, COMMIT}.
- Sub-module cache_beat_counter (params BEATSPERLINE):
  - Inputs: clk, reset, en, ack.
  - Outputs: count, last.
  - count wraps to 0 on the last ack.
  - last = ack & (count == BEATSPERLINE-1).

Test Plan:
- Clean miss, NUMWAYS=4, BEATSPERLINE=4, MissSet=7'h15, VictimWay=4'b0100, DirtyWay=0, BusAck=1 continuous:
  - BusWrite never 1; ClearValid at cycle 2; 4 beats with BeatCount 0..3.
  - MissDone/SetValid/LRUWriteEn at cycle 6; SetQ=7'h15; VictimWayQ=4'b0100.
- Dirty miss, VictimWay=4'b0010, DirtyWay=4'b0010:
  - 4 beats with BusWrite=1, then 4 beats with BusWrite=0.
  - MissDone at cycle 10; BeatCount returns to 0 between bursts.
- Non-dirty victim but other ways dirty (VictimWay=4'b0001, DirtyWay=4'b1110) → no EVICT; MissDone at cycle 6.
- Stalled bus: BusAck pattern 1,0,0,1,1,0,1 in FILL → BeatCount advances only on acks; MissDone one cycle after the 4th ack.
- FlushStage=1 in CAPTURE:
  - Returns to IDLE at cycle 2; BusReq, ClearValid and MissDone stay 0; MissReady=1 at cycle 2.
  - FlushStage=1 during FILL → no effect; MissDone at cycle 6.
- Reset low during EVICT beat 2 → same cycle: BusReq=0, BeatCount=0, VictimWayQ=0. After release, MissReady=1 and a new clean miss completes at cycle 6.

Source files
------------

// File: rtl/cache_miss_sequencer_pkg.sv
// Shared types and helpers for the cache miss sequencer slice.
// Imported by the interface, the beat counter and the top level.
package cache_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    EVICT,
    FILL,
    COMMIT
  } seqstate_t;

  // Beat index width; never below one bit so the port stays legal.
  function automatic int beatWidth(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/cache_miss_sequencer_if.sv
// Miss request, array update and bus beat signals between the sequencer
// (slave side) and the cache arrays / LSU / bus interface (master side).
interface cache_miss_sequencer_if
  import cache_seq_pkg::*;
#(
  parameter int NUMWAYS      = 4,
  parameter int SETLEN       = 7,
  parameter int BEATSPERLINE = 4
);
  localparam int CW = beatWidth(BEATSPERLINE);

  logic               FlushStage;
  logic               MissReq;
  logic [SETLEN-1:0]  MissSet;
  logic               MissReady;
  logic [NUMWAYS-1:0] VictimWay;
  logic [NUMWAYS-1:0] DirtyWay;
  logic [NUMWAYS-1:0] VictimWayQ;
  logic [SETLEN-1:0]  SetQ;
  logic               BusReq;
  logic               BusWrite;
  logic               BusAck;
  logic [CW-1:0]      BeatCount;
  logic               ClearValid;
  logic               SetValid;
  logic               ClearDirty;
  logic               LRUWriteEn;
  logic               MissDone;

  modport slave (
    input  FlushStage, MissReq, MissSet, VictimWay, DirtyWay, BusAck,
    output MissReady, VictimWayQ, SetQ, BusReq, BusWrite, BeatCount,
           ClearValid, SetValid, ClearDirty, LRUWriteEn, MissDone
  );

  modport master (
    output FlushStage, MissReq, MissSet, VictimWay, DirtyWay, BusAck,
    input  MissReady, VictimWayQ, SetQ, BusReq, BusWrite, BeatCount,
           ClearValid, SetValid, ClearDirty, LRUWriteEn, MissDone
  );

endinterface

// File: rtl/cache_miss_sequencer_beat_counter.sv
// Counts accepted bus beats within one line transfer; wraps to zero on the
// last beat so back-to-back evict and fill bursts both start at beat 0.
module cache_beat_counter
  import cache_seq_pkg::*;
#(
  parameter  int BEATSPERLINE = 4,
  localparam int CW           = beatWidth(BEATSPERLINE)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          ack,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LASTBEAT = CW'(BEATSPERLINE - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (en && ack) begin
      r_count <= (r_count == LASTBEAT) ? '0 : r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign last  = ack & (r_count == LASTBEAT);

endmodule

// File: rtl/cache_miss_sequencer.sv
// Sequences one cache-line miss: capture victim, optional dirty writeback,
// line fill, then a single-cycle commit of valid/dirty/LRU state.
module cache_miss_sequencer
  import cache_seq_pkg::*;
#(
  parameter int NUMWAYS      = 4,
  parameter int SETLEN       = 7,
  parameter int BEATSPERLINE = 4
)(
  input logic                    clk,
  input logic                    reset,
  cache_miss_sequencer_if.slave  io
);

  localparam int CW = beatWidth(BEATSPERLINE);

  seqstate_t          r_state;
  seqstate_t          r_prevState;
  seqstate_t          w_nextState;
  logic [NUMWAYS-1:0] r_victimWayQ;
  logic [SETLEN-1:0]  r_setQ;
  logic [CW-1:0]      w_beatCount;
  logic               w_beatLast;
  logic               w_busActive;
  logic               w_accept;
  logic               w_dirtyVictim;

  logic w_missReady;
  logic w_busReq;
  logic w_busWrite;
  logic w_clearValid;
  logic w_commit;

  assign w_accept      = (r_state == IDLE) && io.MissReq && !io.FlushStage;
  assign w_dirtyVictim = |(io.VictimWay & io.DirtyWay);
  assign w_busActive   = (r_state == EVICT) || (r_state == FILL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_prevState <= IDLE;
    end else begin
      r_state     <= w_nextState;
      r_prevState <= r_state;
    end
  end

  // Set index is taken at acceptance; the victim only once the arrays have been read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_setQ       <= '0;
      r_victimWayQ <= '0;
    end else begin
      if (w_accept) begin
        r_setQ <= io.MissSet;
      end
      if (r_state == CAPTURE) begin
        r_victimWayQ <= io.VictimWay;
      end
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_missReady  = 1'b0;
    w_busReq     = 1'b0;
    w_busWrite   = 1'b0;
    w_clearValid = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        w_missReady = 1'b1;
        if (w_accept) begin
          w_nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        if (io.FlushStage) begin
          w_nextState = IDLE;
        end else if (w_dirtyVictim) begin
          w_nextState = EVICT;
        end else begin
          w_nextState = FILL;
        end
      end
      EVICT: begin
        w_busReq   = 1'b1;
        w_busWrite = 1'b1;
        if (w_beatLast) begin
          w_nextState = FILL;
        end
      end
      FILL: begin
        w_busReq     = 1'b1;
        w_clearValid = (r_prevState != FILL);
        if (w_beatLast) begin
          w_nextState = COMMIT;
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  cache_beat_counter #(
    .BEATSPERLINE(BEATSPERLINE)
  ) u_beatCounter (
    .clk  (clk),
    .reset(reset),
    .en   (w_busActive),
    .ack  (io.BusAck),
    .count(w_beatCount),
    .last (w_beatLast)
  );

  assign io.MissReady  = w_missReady;
  assign io.VictimWayQ = r_victimWayQ;
  assign io.SetQ       = r_setQ;
  assign io.BusReq     = w_busReq;
  assign io.BusWrite   = w_busWrite;
  assign io.BeatCount  = w_beatCount;
  assign io.ClearValid = w_clearValid;
  assign io.SetValid   = w_commit;
  assign io.ClearDirty = w_commit;
  assign io.LRUWriteEn = w_commit;
  assign io.MissDone   = w_commit;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Randomized self-checking bench: a transaction-level model predicts each
// cycle from beat counts (writeback beats, then fill beats) for every miss.
module tb_cache_miss_sequencer;

  localparam int NUMWAYS = 4;
  localparam int SETLEN  = 7;
  localparam int BEATS   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int nChecks = 0;
  int nFail   = 0;
  int ackPattern[$];

  logic [SETLEN-1:0]  expSetQ;
  logic [NUMWAYS-1:0] expVictimQ;

  cache_miss_sequencer_if #(
    .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .BEATSPERLINE(BEATS)
  ) bus ();

  cache_miss_sequencer #(
    .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .BEATSPERLINE(BEATS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic missReq, input logic flush, input logic ack);
    bus.MissReq    = missReq;
    bus.FlushStage = flush;
    bus.BusAck     = ack;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"},      int'(bus.MissReady),  1);
    checkOutput({tag, "_busreq"},     int'(bus.BusReq),     0);
    checkOutput({tag, "_beat"},       int'(bus.BeatCount),  0);
    checkOutput({tag, "_clearvalid"}, int'(bus.ClearValid), 0);
    checkOutput({tag, "_commit"},     int'({bus.SetValid, bus.ClearDirty, bus.LRUWriteEn, bus.MissDone}), 0);
    checkOutput({tag, "_setq"},       int'(bus.SetQ),       int'(expSetQ));
    checkOutput({tag, "_victimq"},    int'(bus.VictimWayQ), int'(expVictimQ));
  endtask

  // flushMode: 0 none, 1 flush in capture, 2 flush held during bursts, 3 random flush in bursts.
  // ackMode: 0 always ack, 1 random ack, 2 fill acks taken from ackPattern.
  task automatic runMiss(input logic [SETLEN-1:0] setIdx, input logic [NUMWAYS-1:0] victim,
                         input logic [NUMWAYS-1:0] dirty, input int ackMode,
                         input int flushMode, input int resetAtBeat);
    int cyc, done, evictBeats, total, guard;
    bit seenFill, allAck;
    logic ackBit, flushBit;

    checkIdle("pre");
    bus.MissSet = setIdx;
    applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    stepCycle();
    cyc = 1;
    expSetQ = setIdx;
    checkOutput("cap_ready",  int'(bus.MissReady), 0);
    checkOutput("cap_busreq", int'(bus.BusReq),    0);
    checkOutput("cap_setq",   int'(bus.SetQ),      int'(setIdx));

    bus.VictimWay = victim;
    bus.DirtyWay  = dirty;
    bus.MissSet   = SETLEN'($urandom);
    applyStimulus(1'($urandom_range(0, 1)), flushMode == 1, 1'($urandom_range(0, 1)));
    stepCycle();
    cyc = 2;
    expVictimQ = victim;
    if (flushMode == 1) begin
      checkIdle("flush");
      applyStimulus(1'b0, 1'b0, 1'b0);
      return;
    end

    evictBeats = ((victim & dirty) != '0) ? BEATS : 0;
    total      = evictBeats + BEATS;
    done       = 0;
    guard      = 0;
    seenFill   = 0;
    allAck     = 1;
    while (done < total && guard < 400) begin
      checkOutput("burst_busreq",     int'(bus.BusReq),     1);
      checkOutput("burst_buswrite",   int'(bus.BusWrite),   int'(done < evictBeats));
      checkOutput("burst_beat",       int'(bus.BeatCount),  done % BEATS);
      checkOutput("burst_clearvalid", int'(bus.ClearValid), int'(done == evictBeats && !seenFill));
      checkOutput("burst_missdone",   int'(bus.MissDone),   0);
      checkOutput("burst_ready",      int'(bus.MissReady),  0);
      checkOutput("burst_victimq",    int'(bus.VictimWayQ), int'(victim));
      checkOutput("burst_setq",       int'(bus.SetQ),       int'(setIdx));

      if (done == resetAtBeat) begin
        reset = 1'b0;
        #1;
        checkOutput("rst_busreq",  int'(bus.BusReq),     0);
        checkOutput("rst_beat",    int'(bus.BeatCount),  0);
        checkOutput("rst_victimq", int'(bus.VictimWayQ), 0);
        checkOutput("rst_setq",    int'(bus.SetQ),       0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
          stepCycle();
          checkOutput("rsthold_busreq", int'(bus.BusReq), 0);
          checkOutput("rsthold_pulses",
                      int'({bus.ClearValid, bus.SetValid, bus.ClearDirty, bus.LRUWriteEn, bus.MissDone}), 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset      = 1'b1;
        expSetQ    = '0;
        expVictimQ = '0;
        stepCycle();
        checkIdle("postrst");
        return;
      end

      if (done >= evictBeats) seenFill = 1;
      if (ackMode == 0) begin
        ackBit = 1'b1;
      end else if (ackMode == 1) begin
        ackBit = 1'($urandom_range(0, 1));
      end else if (done >= evictBeats && ackPattern.size() > 0) begin
        ackBit = 1'(ackPattern.pop_front());
      end else begin
        ackBit = 1'b1;
      end
      if (!ackBit) allAck = 0;
      flushBit = (flushMode == 2) ? 1'b1 :
                 (flushMode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.VictimWay = NUMWAYS'($urandom);
      bus.DirtyWay  = NUMWAYS'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), flushBit, ackBit);
      stepCycle();
      cyc++;
      guard++;
      if (ackBit) done++;
    end
    checkOutput("burst_bound", done, total);

    checkOutput("commit_missdone",   int'(bus.MissDone),   1);
    checkOutput("commit_setvalid",   int'(bus.SetValid),   1);
    checkOutput("commit_cleardirty", int'(bus.ClearDirty), 1);
    checkOutput("commit_lru",        int'(bus.LRUWriteEn), 1);
    checkOutput("commit_busreq",     int'(bus.BusReq),     0);
    checkOutput("commit_clearvalid", int'(bus.ClearValid), 0);
    checkOutput("commit_beat",       int'(bus.BeatCount),  0);
    checkOutput("commit_ready",      int'(bus.MissReady),  0);
    checkOutput("commit_setq",       int'(bus.SetQ),       int'(setIdx));
    checkOutput("commit_victimq",    int'(bus.VictimWayQ), int'(victim));
    if (allAck) checkOutput("latency", cyc, 2 + total);

    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    stepCycle();
    checkIdle("post");
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ignoredRequest();
    bus.MissSet = SETLEN'($urandom);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle();
    checkIdle("ignored");
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NUMWAYS-1:0] v, d;
    int fm, rb, pick;

    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.MissSet   = '0;
    bus.VictimWay = '0;
    bus.DirtyWay  = '0;
    expSetQ       = '0;
    expVictimQ    = '0;
    reset         = 1'b0;
    #12;
    checkOutput("reset_busreq",  int'(bus.BusReq),     0);
    checkOutput("reset_beat",    int'(bus.BeatCount),  0);
    checkOutput("reset_victimq", int'(bus.VictimWayQ), 0);
    checkOutput("reset_setq",    int'(bus.SetQ),       0);
    checkOutput("reset_pulses",
                int'({bus.ClearValid, bus.SetValid, bus.ClearDirty, bus.LRUWriteEn, bus.MissDone}), 0);
    reset = 1'b1;
    stepCycle();
    checkIdle("reset_release");

    runMiss(7'h15, 4'b0100, 4'b0000, 0, 0, -1);
    runMiss(SETLEN'($urandom), 4'b0010, 4'b0010, 0, 0, -1);
    runMiss(SETLEN'($urandom), 4'b0001, 4'b1110, 0, 0, -1);
    ackPattern = '{1, 0, 0, 1, 1, 0, 1};
    runMiss(SETLEN'($urandom), 4'b1000, 4'b0000, 2, 0, -1);
    runMiss(SETLEN'($urandom), 4'b0100, 4'b0100, 0, 1, -1);
    runMiss(SETLEN'($urandom), 4'b0001, 4'b0000, 0, 2, -1);
    runMiss(SETLEN'($urandom), 4'b0010, 4'b0010, 0, 0, 2);
    runMiss(SETLEN'($urandom), 4'b0001, 4'b0000, 0, 0, -1);
    ignoredRequest();

    for (int i = 0; i < 40; i++) begin
      v    = NUMWAYS'(1) << $urandom_range(0, NUMWAYS - 1);
      d    = NUMWAYS'($urandom);
      pick = $urandom_range(0, 9);
      fm   = (pick == 0) ? 1 : (pick == 1) ? 3 : (pick == 2) ? 2 : 0;
      rb   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2 * BEATS - 1) : -1;
      if ($urandom_range(0, 4) == 0) ignoredRequest();
      runMiss(SETLEN'($urandom), v, d, $urandom_range(0, 1), fm, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
